// File: rtl/udp_pkg.sv
// rtl/udp_pkg.sv - shared types, constants and ones'-complement helper for the UDP layer
package udp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HDR1    = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_DROP    = 2'd3
   } udp_state_e;

   localparam logic [15:0] UDP_HDR_BYTES = 16'd8;

   // 16-bit ones'-complement add; the carry out is wrapped back into bit 0
   function automatic logic [15:0] oc_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'b0, s[16]};
   endfunction

endpackage

// File: rtl/ones_comp_acc.sv
// rtl/ones_comp_acc.sv - registered ones'-complement accumulator taking up to three terms per cycle
module ones_comp_acc (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear_i,
   input  logic        seed_i,
   input  logic        add_i,
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic [15:0] c_i,
   output logic [15:0] acc_o,
   output logic [15:0] next_o
);
   import udp_pkg::*;

   logic [15:0] acc_q, acc_d;
   logic [15:0] base;
   logic [17:0] sum18;

   // Four 16-bit values fit in 18 bits; oc_add16 folds the two top bits back in
   always_comb begin
      base   = seed_i ? 16'd0 : acc_q;
      sum18  = {2'b0, base} + {2'b0, a_i} + {2'b0, b_i} + {2'b0, c_i};
      acc_d  = acc_q;
      if (clear_i) begin
         acc_d = 16'd0;
      end else if (seed_i || add_i) begin
         acc_d = oc_add16(sum18[15:0], {14'b0, sum18[17:16]});
      end
   end

   // Accumulator register
   always_ff @(posedge clk) begin
      if (!rst_n) acc_q <= 16'd0;
      else        acc_q <= acc_d;
   end

   assign acc_o  = acc_q;
   assign next_o = acc_d;

endmodule

// File: rtl/udp_rx_layer.sv
// rtl/udp_rx_layer.sv - UDP receive: header parse, port filter, payload forward, checksum verdict
module udp_rx_layer #(
   parameter logic [15:0] LOCAL_PORT = 16'd68
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rcv_op_st,
   input  logic        rcv_op,
   input  logic        rcv_op_end,
   input  logic [31:0] rcv_data,
   input  logic [15:0] pseudo_crc_sum_i,
   output logic        app_op_st,
   output logic        app_op,
   output logic        app_op_end,
   output logic [31:0] app_data,
   output logic [3:0]  app_be,
   output logic        app_pkt_ok,
   output logic [15:0] src_port_o,
   output logic [15:0] dst_port_o,
   output logic [15:0] udp_len_o,
   output logic [15:0] udp_csum_o,
   output logic [15:0] csum_o
);
   import udp_pkg::*;

   udp_state_e  state_q, state_d;
   logic [15:0] remain_q, remain_d;
   logic        emitted_q, emitted_d, ended_q, ended_d;
   logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d, ucs_q, ucs_d;
   logic        st_q, st_d, op_q, op_d, end_q, end_d, ok_q, ok_d;
   logic [31:0] data_q, data_d;
   logic [3:0]  be_q, be_d;

   logic        acc_seed, acc_add;
   logic [15:0] term_a, term_b, term_c, acc_q, acc_next;
   logic [3:0]  be_mask;
   logic [31:0] masked_word;
   logic [15:0] remain_nx, remain_after;
   logic        start, emit;

   // Payload datapath: leading-byte mask, masked word and accumulator terms for this beat
   always_comb begin
      start    = rcv_op && rcv_op_st;
      emit     = rcv_op && !rcv_op_st && (state_q == ST_PAYLOAD) && !ended_q && (remain_q != 16'd0);
      be_mask  = (remain_q >= 16'd4) ? 4'hF :
                 (remain_q == 16'd3) ? 4'hE :
                 (remain_q == 16'd2) ? 4'hC : 4'h8;
      masked_word = rcv_data & {{8{be_mask[3]}}, {8{be_mask[2]}}, {8{be_mask[1]}}, {8{be_mask[0]}}};
      remain_nx   = (remain_q >= 16'd4) ? (remain_q - 16'd4) : 16'd0;
      remain_after = emit ? remain_nx : remain_q;
      acc_seed = start;
      acc_add  = 1'b0;
      term_a   = 16'd0;
      term_b   = 16'd0;
      term_c   = 16'd0;
      if (start) begin
         term_a = rcv_data[31:16];
         term_b = rcv_data[15:0];
         term_c = pseudo_crc_sum_i;
      end else if (rcv_op && (state_q == ST_HDR1)) begin
         // Length counts twice: once in the pseudo-header, once in the UDP header
         acc_add = 1'b1;
         term_a  = rcv_data[31:16];
         term_b  = rcv_data[31:16];
         term_c  = rcv_data[15:0];
      end else if (emit) begin
         acc_add = 1'b1;
         term_a  = masked_word[31:16];
         term_b  = masked_word[15:0];
      end
   end

   ones_comp_acc u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (1'b0),
      .seed_i  (acc_seed),
      .add_i   (acc_add),
      .a_i     (term_a),
      .b_i     (term_b),
      .c_i     (term_c),
      .acc_o   (acc_q),
      .next_o  (acc_next)
   );

   // Parser FSM and registered application outputs
   always_comb begin
      state_d   = state_q;
      remain_d  = remain_q;
      emitted_d = emitted_q;
      ended_d   = ended_q;
      src_d     = src_q;
      dst_d     = dst_q;
      len_d     = len_q;
      ucs_d     = ucs_q;
      st_d      = 1'b0;
      op_d      = 1'b0;
      end_d     = 1'b0;
      ok_d      = 1'b0;
      data_d    = 32'd0;
      be_d      = 4'd0;
      if (start) begin
         // A new start always wins, abandoning whatever was in flight
         src_d     = rcv_data[31:16];
         dst_d     = rcv_data[15:0];
         remain_d  = 16'd0;
         emitted_d = 1'b0;
         ended_d   = 1'b0;
         state_d   = ST_HDR1;
      end else if (rcv_op) begin
         unique case (state_q)
            ST_IDLE: begin
            end
            ST_HDR1: begin
               len_d = rcv_data[31:16];
               ucs_d = rcv_data[15:0];
               if (rcv_op_end) begin
                  state_d = ST_IDLE;
               end else if ((dst_q != LOCAL_PORT) || (rcv_data[31:16] < UDP_HDR_BYTES)) begin
                  state_d = ST_DROP;
               end else begin
                  remain_d = rcv_data[31:16] - UDP_HDR_BYTES;
                  state_d  = ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               if (emit) begin
                  op_d      = 1'b1;
                  st_d      = !emitted_q;
                  data_d    = masked_word;
                  be_d      = be_mask;
                  remain_d  = remain_nx;
                  emitted_d = 1'b1;
               end
               // Close on the last datagram byte, or early on a truncated/empty datagram
               if (!ended_q && ((emit && (remain_nx == 16'd0)) || rcv_op_end)) begin
                  end_d   = 1'b1;
                  ended_d = 1'b1;
                  ok_d    = ((ucs_q == 16'd0) || (acc_next == 16'hFFFF)) && (remain_after == 16'd0);
                  if (!emitted_q && !emit) st_d = 1'b1;
               end
               if (rcv_op_end) state_d = ST_IDLE;
            end
            ST_DROP: begin
               if (rcv_op_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         remain_q  <= 16'd0;
         emitted_q <= 1'b0;
         ended_q   <= 1'b0;
         src_q     <= 16'd0;
         dst_q     <= 16'd0;
         len_q     <= 16'd0;
         ucs_q     <= 16'd0;
         st_q      <= 1'b0;
         op_q      <= 1'b0;
         end_q     <= 1'b0;
         ok_q      <= 1'b0;
         data_q    <= 32'd0;
         be_q      <= 4'd0;
      end else begin
         state_q   <= state_d;
         remain_q  <= remain_d;
         emitted_q <= emitted_d;
         ended_q   <= ended_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         len_q     <= len_d;
         ucs_q     <= ucs_d;
         st_q      <= st_d;
         op_q      <= op_d;
         end_q     <= end_d;
         ok_q      <= ok_d;
         data_q    <= data_d;
         be_q      <= be_d;
      end
   end

   assign app_op_st  = st_q;
   assign app_op     = op_q;
   assign app_op_end = end_q;
   assign app_data   = data_q;
   assign app_be     = be_q;
   assign app_pkt_ok = ok_q;
   assign src_port_o = src_q;
   assign dst_port_o = dst_q;
   assign udp_len_o  = len_q;
   assign udp_csum_o = ucs_q;
   assign csum_o     = acc_q;

endmodule

// File: tb/tb_udp_rx_layer.sv
// tb/tb_udp_rx_layer.sv - table-driven scoreboard bench for udp_rx_layer
module tb_udp_rx_layer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rcv_op_st, rcv_op, rcv_op_end;
   logic [31:0] rcv_data;
   logic [15:0] pseudo_crc_sum_i;
   logic        app_op_st, app_op, app_op_end, app_pkt_ok;
   logic [31:0] app_data;
   logic [3:0]  app_be;
   logic [15:0] src_port_o, dst_port_o, udp_len_o, udp_csum_o, csum_o;

   always #5 clk = ~clk;

   udp_rx_layer #(.LOCAL_PORT(16'd68)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .rcv_op_st        (rcv_op_st),
      .rcv_op           (rcv_op),
      .rcv_op_end       (rcv_op_end),
      .rcv_data         (rcv_data),
      .pseudo_crc_sum_i (pseudo_crc_sum_i),
      .app_op_st        (app_op_st),
      .app_op           (app_op),
      .app_op_end       (app_op_end),
      .app_data         (app_data),
      .app_be           (app_be),
      .app_pkt_ok       (app_pkt_ok),
      .src_port_o       (src_port_o),
      .dst_port_o       (dst_port_o),
      .udp_len_o        (udp_len_o),
      .udp_csum_o       (udp_csum_o),
      .csum_o           (csum_o)
   );

   typedef struct {
      logic        op;
      logic        st;
      logic        en;
      logic [31:0] data;
      logic [3:0]  be;
      logic        ok;
   } beat_t;

   typedef struct {
      logic [15:0] dst;
      logic [15:0] len;
      int          nwords;
      int          kind;
      bit          zero_csum;
      bit          flip;
      bit          exp_ok;
   } vec_t;

   beat_t       exp_q[$];
   beat_t       got;
   vec_t        vecs[10];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [15:0] last_csum;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Scoreboard: every output beat or marker must match the oldest expectation
   always @(negedge clk) begin
      if (app_op || app_op_st || app_op_end) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_beat: got data %h be %h end %b expected none", app_data, app_be, app_op_end);
         end else begin
            got = exp_q.pop_front();
            chk("app_op", {31'd0, app_op}, {31'd0, got.op});
            chk("app_op_st", {31'd0, app_op_st}, {31'd0, got.st});
            chk("app_op_end", {31'd0, app_op_end}, {31'd0, got.en});
            chk("app_data", app_data, got.data);
            chk("app_be", {28'd0, app_be}, {28'd0, got.be});
            if (got.en) chk("app_pkt_ok", {31'd0, app_pkt_ok}, {31'd0, got.ok});
         end
      end
   end

   task automatic send_pkt(input vec_t v, input logic [15:0] src, input bit abort);
      int           plen, rem;
      logic [31:0]  w[$];
      logic [31:0]  sum, word, pat, edata;
      logic [15:0]  pseudo, csum;
      logic [7:0]   p[64];
      logic [7:0]   b2;
      logic [3:0]   be;
      beat_t        e;
      bit           accepted;
      pat    = 32'hDEADBEEF;
      plen   = (v.len >= 16'd8) ? int'(v.len) - 8 : 0;
      pseudo = 16'($urandom);
      for (int i = 0; i < 64; i++) begin
         case (v.kind)
            1:       p[i] = pat[31 - 8 * (i % 4) -: 8];
            2:       p[i] = 8'(i + 1);
            default: p[i] = 8'($urandom);
         endcase
      end
      sum = {16'd0, pseudo} + {16'd0, v.len} + {16'd0, src} + {16'd0, v.dst} + {16'd0, v.len};
      for (int i = 0; i < plen; i += 2) begin
         b2  = (i + 1 < plen) ? p[i + 1] : 8'h00;
         sum = sum + {16'd0, p[i], b2};
      end
      while (sum[31:16] != 16'd0) sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
      csum = ~sum[15:0];
      if (csum == 16'd0) csum = 16'hFFFF;
      if (v.zero_csum) csum = 16'd0;
      if (v.flip) p[0] = p[0] ^ 8'h10;
      last_csum = csum;

      w.push_back({src, v.dst});
      w.push_back({v.len, csum});
      for (int k = 0; k < v.nwords; k++) begin
         for (int j = 0; j < 4; j++) word[31 - 8 * j -: 8] = (4 * k + j < plen) ? p[4 * k + j] : 8'hA5;
         w.push_back(word);
      end

      accepted = (v.dst == 16'd68) && (v.len >= 16'd8);
      if (accepted && plen == 0 && !abort) begin
         e = '{op: 1'b0, st: 1'b1, en: 1'b1, data: 32'd0, be: 4'd0, ok: v.exp_ok};
         exp_q.push_back(e);
      end else if (accepted) begin
         for (int k = 0; k < v.nwords; k++) begin
            if (4 * k < plen) begin
               rem = plen - 4 * k;
               be  = (rem >= 4) ? 4'hF : (rem == 3) ? 4'hE : (rem == 2) ? 4'hC : 4'h8;
               for (int j = 0; j < 4; j++) edata[31 - 8 * j -: 8] = be[3 - j] ? p[4 * k + j] : 8'h00;
               e = '{op: 1'b1, st: (k == 0), en: (rem <= 4) || (k == v.nwords - 1 && !abort),
                     data: edata, be: be, ok: v.exp_ok};
               exp_q.push_back(e);
            end
         end
      end

      for (int i = 0; i < w.size(); i++) begin
         @(negedge clk);
         rcv_op           = 1'b1;
         rcv_op_st        = (i == 0);
         rcv_op_end       = (i == w.size() - 1) && !abort;
         rcv_data         = w[i];
         pseudo_crc_sum_i = pseudo;
      end
      if (!abort) begin
         @(negedge clk);
         rcv_op     = 1'b0;
         rcv_op_st  = 1'b0;
         rcv_op_end = 1'b0;
         rcv_data   = 32'd0;
      end
   endtask

   task automatic check_hdr(input string tag, input logic [15:0] src, input vec_t v);
      repeat (3) @(negedge clk);
      chk({tag, "_src_port"}, {16'd0, src_port_o}, {16'd0, src});
      chk({tag, "_dst_port"}, {16'd0, dst_port_o}, {16'd0, v.dst});
      chk({tag, "_udp_len"}, {16'd0, udp_len_o}, {16'd0, v.len});
      chk({tag, "_udp_csum"}, {16'd0, udp_csum_o}, {16'd0, last_csum});
      chk({tag, "_beats_pending"}, exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      vec_t v;
      rst_n = 1'b0; rcv_op = 1'b0; rcv_op_st = 1'b0; rcv_op_end = 1'b0;
      rcv_data = 32'd0; pseudo_crc_sum_i = 16'd0;
      repeat (3) @(negedge clk);
      chk("rst_app_op", {31'd0, app_op}, 32'd0);
      chk("rst_app_op_end", {31'd0, app_op_end}, 32'd0);
      chk("rst_app_data", app_data, 32'd0);
      chk("rst_src_port", {16'd0, src_port_o}, 32'd0);
      chk("rst_csum", {16'd0, csum_o}, 32'd0);
      rst_n = 1'b1;

      //          dst     len     nw kind zc flip ok
      vecs[0] = '{16'd68, 16'd12, 3, 1,   0, 0,   1};  // good, two pad words
      vecs[1] = '{16'd68, 16'd13, 2, 2,   0, 0,   1};  // odd length
      vecs[2] = '{16'd68, 16'd16, 2, 0,   0, 1,   0};  // corrupt payload bit
      vecs[3] = '{16'd68, 16'd20, 3, 0,   1, 1,   1};  // checksum disabled
      vecs[4] = '{16'd67, 16'd12, 1, 1,   0, 0,   0};  // wrong port
      vecs[5] = '{16'd68, 16'd20, 2, 0,   0, 0,   0};  // truncated
      vecs[6] = '{16'd68, 16'd8,  1, 0,   0, 0,   1};  // zero-length payload
      vecs[7] = '{16'd68, 16'd38, 8, 0,   0, 0,   1};  // long, be=C tail
      vecs[8] = '{16'd68, 16'd4,  2, 0,   0, 0,   0};  // length below header size
      vecs[9] = '{16'd68, 16'd9,  2, 2,   0, 0,   1};  // single byte, one pad

      for (int i = 0; i < 10; i++) begin
         send_pkt(vecs[i], 16'h1000 + 16'(i), 1'b0);
         check_hdr("vec", 16'h1000 + 16'(i), vecs[i]);
      end

      // Restart: a new start word mid-payload abandons the first packet
      v = '{16'd68, 16'd20, 1, 0, 0, 0, 0};
      send_pkt(v, 16'h2000, 1'b1);
      send_pkt(vecs[1], 16'h2001, 1'b0);
      check_hdr("restart", 16'h2001, vecs[1]);

      // Reset mid-packet clears every output on the following cycle
      v = '{16'd68, 16'd20, 2, 0, 0, 0, 0};
      send_pkt(v, 16'h3000, 1'b1);
      @(negedge clk);
      rst_n = 1'b0; rcv_op = 1'b0; rcv_op_st = 1'b0; rcv_op_end = 1'b0;
      @(negedge clk);
      chk("mid_rst_app_op", {31'd0, app_op}, 32'd0);
      chk("mid_rst_app_op_end", {31'd0, app_op_end}, 32'd0);
      chk("mid_rst_app_data", app_data, 32'd0);
      chk("mid_rst_app_be", {28'd0, app_be}, 32'd0);
      chk("mid_rst_src_port", {16'd0, src_port_o}, 32'd0);
      chk("mid_rst_udp_len", {16'd0, udp_len_o}, 32'd0);
      chk("mid_rst_csum", {16'd0, csum_o}, 32'd0);
      chk("mid_rst_pending", exp_q.size(), 32'd0);
      exp_q.delete();
      rst_n = 1'b1;
      @(negedge clk);
      send_pkt(vecs[0], 16'h3001, 1'b0);
      check_hdr("post_rst", 16'h3001, vecs[0]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
